// File: rtl/snail_pkg.sv
// Shared constants and mode encodings for the snail family of serial detectors.
package snail_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned LEN_W_DEF   = 4;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam logic [7:0]  RST_PAT_DEF = 8'h01;
  localparam int unsigned RST_LEN_DEF = 2;

  typedef enum logic {
    NOVL = 1'b0,
    OVL  = 1'b1
  } ovl_mode_e;

endpackage

// File: rtl/snail_sat_counter.sv
// Saturating up-counter; clear wins over a same-cycle increment.
module snail_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/snail_seq_detector.sv
// Programmable serial pattern detector with overlap control, hit pulse and
// saturating hit counter.
module snail_seq_detector
  import snail_pkg::*;
#(
  parameter int unsigned         MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned         LEN_W   = LEN_W_DEF,
  parameter int unsigned         CNT_W   = CNT_W_DEF,
  parameter logic [MAX_LEN-1:0]  RST_PAT = MAX_LEN'(RST_PAT_DEF),
  parameter int unsigned         RST_LEN = RST_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               a,
  input  logic               a_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   hit_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  ovl_mode_e          r_overlap;
  logic               r_cfg_err;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_y;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_cfg_bad;
  logic               w_match;

  // A bit arriving in the cfg_load cycle is dropped along with the flushed history.
  assign w_accept    = a_valid && !cfg_load;
  assign w_hist_next = {r_hist[MAX_LEN-2:0], a};
  assign w_fill_next = (r_fill >= LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_cfg_bad   = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));

  // Only the low len bits of the pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < r_len) w_mask[i] = 1'b1;
    end
  end

  assign w_match = w_accept && !r_cfg_err && (w_fill_next >= r_len) &&
                   (((w_hist_next ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pat     <= RST_PAT;
      r_len     <= LEN_W'(RST_LEN);
      r_overlap <= OVL;
      r_cfg_err <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_y       <= 1'b0;
    end else if (cfg_load) begin
      r_pat     <= cfg_pattern;
      r_len     <= cfg_len;
      r_overlap <= ovl_mode_e'(cfg_overlap);
      r_cfg_err <= w_cfg_bad;
      r_hist    <= '0;
      r_fill    <= '0;
      r_y       <= 1'b0;
    end else if (w_accept) begin
      r_hist <= w_hist_next;
      // Non-overlapping mode demands len fresh bits before the next hit.
      r_fill <= (w_match && (r_overlap == NOVL)) ? '0 : w_fill_next;
      r_y    <= w_match;
    end else begin
      r_y <= 1'b0;
    end
  end

  snail_sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_match),
    .clr     (cnt_clr),
    .count   (hit_count)
  );

  assign y       = r_y;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_snail_seq_detector.sv
// Scoreboard bench: a bit-queue reference model pushes expected outputs per
// cycle; they are popped and compared just after the following clock edge.
module tb_snail_seq_detector;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a, a_valid, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       y, cfg_err, y2, cfg_err2;
  logic [7:0] hit_count;
  logic [1:0] hit_count2;

  typedef struct {
    int y;
    int cnt8;
    int cnt2;
    int err;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;

  logic [7:0] m_pat;
  int         m_len;
  int         m_ovl;
  int         m_err;
  int         m_bits[$];
  int         m_cnt8;
  int         m_cnt2;

  always #5 clk = ~clk;

  snail_seq_detector dut (
    .clk(clk), .reset_n(reset_n), .a(a), .a_valid(a_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y), .hit_count(hit_count), .cfg_err(cfg_err)
  );

  snail_seq_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .a(a), .a_valid(a_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y2), .hit_count(hit_count2), .cfg_err(cfg_err2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input logic rst, input logic v, input logic b, input logic ld,
                      input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic clr, input string tag);
    exp_t e;
    int   hit;
    @(negedge clk);
    reset_n = !rst; a_valid = v; a = b; cfg_load = ld;
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cnt_clr = clr;
    hit = 0;
    if (rst) begin
      m_pat = 8'h01; m_len = 2; m_ovl = 1; m_err = 0;
      m_bits.delete(); m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (ld) begin
        m_pat = p; m_len = int'(l); m_ovl = int'(o);
        m_err = (l == 4'd0 || l > 4'd8) ? 1 : 0;
        m_bits.delete();
      end else if (v) begin
        m_bits.push_back(int'(b));
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        if (m_err == 0 && m_bits.size() >= m_len) begin
          hit = 1;
          for (int k = 0; k < m_len; k++)
            if (m_bits[m_bits.size() - m_len + k] != int'(m_pat[m_len - 1 - k])) hit = 0;
          if (hit == 1 && m_ovl == 0) m_bits.delete();
        end
      end
      if (clr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (hit == 1) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    e.y = hit; e.cnt8 = m_cnt8; e.cnt2 = m_cnt2; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".y"}, int'(y), e.y);
    chk({tag, ".y2"}, int'(y2), e.y);
    chk({tag, ".cnt"}, int'(hit_count), e.cnt8);
    chk({tag, ".cnt2"}, int'(hit_count2), e.cnt2);
    chk({tag, ".err"}, int'(cfg_err), e.err);
  endtask

  task automatic bit_in(input logic b, input string tag);
    step(1'b0, 1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b1, p, l, o, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
  endtask

  task automatic stream(input logic [7:0] bits, input int n, input string tag);
    logic [7:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) bit_in(v[i], tag);
  endtask

  initial begin
    reset_n = 1'b0; a = 1'b0; a_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;

    do_reset("rst0");
    do_reset("rst1");

    // Default "01" detector: hits after bits 3 and 6.
    stream(8'b101101, 6, "t1");
    chk("t1.total", int'(hit_count), 2);

    // 1011 overlapping then non-overlapping.
    load(8'b1011, 4'd4, 1'b1, "t2.ld");
    stream(8'b1011011, 7, "t2.ovl");
    load(8'b1011, 4'd4, 1'b0, "t2.ld2");
    stream(8'b1011011, 7, "t2.novl");

    // 01 with idle gaps.
    load(8'h01, 4'd2, 1'b1, "t3.ld");
    bit_in(1'b0, "t3");
    idle("t3.idle"); idle("t3.idle"); idle("t3.idle");
    bit_in(1'b1, "t3");
    idle("t3.after");

    // Invalid length, recovery, and a bit dropped in the load cycle.
    load(8'h01, 4'd0, 1'b1, "t4.bad");
    stream(8'b0101, 4, "t4.dis");
    load(8'h05, 4'd9, 1'b1, "t4.bad9");
    stream(8'b0101, 4, "t4.dis9");
    load(8'h01, 4'd2, 1'b1, "t4.ok");
    stream(8'b0101, 4, "t4.res");
    bit_in(1'b0, "t4.pre");
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 4'd2, 1'b1, 1'b0, "t4.drop");
    bit_in(1'b1, "t4.nohit");
    stream(8'b01, 2, "t4.hit");

    // Saturation on the narrow counter, then clear coinciding with a hit.
    stream(8'b01010101, 8, "t5.sat");
    stream(8'b0101, 4, "t5.sat2");
    bit_in(1'b0, "t5.c");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, "t5.clr");
    idle("t5.post");

    // Ignored upper pattern bits.
    load(8'hF1, 4'd2, 1'b1, "t5b.ld");
    stream(8'b0001, 4, "t5b");

    // Reset mid-pattern.
    load(8'b1011, 4'd4, 1'b1, "t6.ld");
    stream(8'b101, 3, "t6.part");
    do_reset("t6.rst");
    bit_in(1'b1, "t6.last");
    stream(8'b01, 2, "t6.def");

    // Random mix of traffic, reloads and clears.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4)
        step(1'b0, 1'($urandom), 1'($urandom), 1'b1, 8'($urandom),
             4'($urandom_range(0, 10)), 1'($urandom), 1'b0, "rnd.ld");
      else if (r < 7)
        step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, "rnd.clr");
      else if (r < 8)
        do_reset("rnd.rst");
      else
        step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 8'h00, 4'd0, 1'b0,
             1'b0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
